// File: rtl/led_timing_pkg.sv
// Shared types, default timing constants and width helper for the LED frame timing core.
package led_timing_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    LATCH  = 2'd2
  } frame_state_e;

  // Default timing for a 12 MHz clock driving a 60-LED strip at 60 Hz.
  localparam int unsigned DEF_SEGMENT_DIV      = 4;
  localparam int unsigned DEF_SEGMENTS_PER_BIT = 4;
  localparam int unsigned DEF_BITS_PER_LED     = 24;
  localparam int unsigned DEF_LEDS_PER_FRAME   = 60;
  localparam int unsigned DEF_RESET_BITS       = 40;
  localparam int unsigned DEF_FRAME_DIV        = 200000;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int unsigned clog2_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/strobe_divider.sv
// Modulo-DIV counter with clear/advance and a registered terminal-count flag.
// last_next_c exposes the flag value for the next cycle so callers can
// build registered strobes aligned with the terminal cycle.
module strobe_divider
  import led_timing_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      advance,
  output logic [clog2_w(DIV)-1:0]   count,
  output logic                      last,
  output logic                      last_next_c
);

  localparam int unsigned CW = clog2_w(DIV);

  logic [CW-1:0] count_q, count_d;
  logic          last_q, last_d;

  // Next count: clear wins, otherwise wrap at DIV-1 when advancing.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (advance) begin
      count_d = last_q ? '0 : count_q + CW'(1);
    end
    last_d = (count_d == CW'(DIV - 1));
  end

  // Count and terminal flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign count       = count_q;
  assign last        = last_q;
  assign last_next_c = last_d;

endmodule

// File: rtl/led_frame_timing_generator.sv
// Single-clock LED frame timing core: segment/bit/LED enable strobes and a
// STREAM -> LATCH -> IDLE frame sequencer started by a free-running frame tick.
// Optional feature: define LED_FRAME_OVERRUN_EN to add the sticky frame_overrun flag.
module led_frame_timing_generator
  import led_timing_pkg::*;
#(
  parameter int unsigned SEGMENT_DIV      = DEF_SEGMENT_DIV,
  parameter int unsigned SEGMENTS_PER_BIT = DEF_SEGMENTS_PER_BIT,
  parameter int unsigned BITS_PER_LED     = DEF_BITS_PER_LED,
  parameter int unsigned LEDS_PER_FRAME   = DEF_LEDS_PER_FRAME,
  parameter int unsigned RESET_BITS       = DEF_RESET_BITS,
  parameter int unsigned FRAME_DIV        = DEF_FRAME_DIV
) (
  input  logic                                 clock_12mhz,
  input  logic                                 reset,
  input  logic                                 enable,
  output logic                                 frame_start,
  output logic                                 bit_segment_strobe,
  output logic                                 bit_strobe,
  output logic                                 led_strobe,
  output logic [clog2_w(BITS_PER_LED)-1:0]     bit_index,
  output logic [clog2_w(LEDS_PER_FRAME)-1:0]   led_index,
  output logic                                 encoder_reset,
  output logic                                 busy
`ifdef LED_FRAME_OVERRUN_EN
  ,
  output logic                                 frame_overrun
`endif
);

  localparam int unsigned BIT_W     = clog2_w(BITS_PER_LED);
  localparam int unsigned LED_W     = clog2_w(LEDS_PER_FRAME);
  localparam int unsigned SEG_W     = clog2_w(SEGMENT_DIV);
  localparam int unsigned BSEG_W    = clog2_w(SEGMENTS_PER_BIT);
  localparam int unsigned LATCH_DIV = RESET_BITS * SEGMENT_DIV * SEGMENTS_PER_BIT;
  localparam int unsigned LATCH_W   = clog2_w(LATCH_DIV);
  localparam int unsigned FRAME_W   = clog2_w(FRAME_DIV);
  localparam int unsigned FRAME_LEN = SEGMENT_DIV * SEGMENTS_PER_BIT * BITS_PER_LED * LEDS_PER_FRAME;

  // A frame that cannot finish streaming before the next tick is a configuration error.
  if (FRAME_LEN >= FRAME_DIV) begin : g_frame_len_check
    $error("led_frame_timing_generator: frame length %0d must be below FRAME_DIV %0d",
           FRAME_LEN, FRAME_DIV);
  end

  frame_state_e state_q, state_d;

  logic frame_start_q, frame_start_d;
  logic seg_strobe_q, seg_strobe_d;
  logic bit_strobe_q, bit_strobe_d;
  logic led_strobe_q, led_strobe_d;
  logic encoder_reset_q, encoder_reset_d;
  logic busy_q, busy_d;

  logic stream_q, stream_d, latch_q, latch_d;
  logic frame_done_c;

  logic               frame_tick;
  logic               seg_last, seg_last_next;
  logic               bseg_last, bseg_last_next;
  logic [BIT_W-1:0]   bit_cnt;
  logic               bit_last, bit_last_next;
  logic [LED_W-1:0]   led_cnt;
  logic               led_last;
  logic               latch_last;

  logic [SEG_W-1:0]   seg_cnt_unused;
  logic [BSEG_W-1:0]  bseg_cnt_unused;
  logic               led_last_next_unused;
  logic [LATCH_W-1:0] latch_cnt_unused;
  logic               latch_last_next_unused;
  logic [FRAME_W-1:0] frame_cnt_unused;
  logic               frame_last_next_unused;

  assign stream_q     = (state_q == STREAM);
  assign stream_d     = (state_d == STREAM);
  assign latch_q      = (state_q == LATCH);
  assign latch_d      = (state_d == LATCH);
  assign frame_done_c = seg_last & bseg_last & bit_last & led_last;

  // Free-running frame timer; terminal count is the frame tick.
  strobe_divider #(.DIV(FRAME_DIV)) u_frame_div (
    .clk(clock_12mhz), .rst(reset), .clear(1'b0), .advance(1'b1),
    .count(frame_cnt_unused), .last(frame_tick), .last_next_c(frame_last_next_unused)
  );

  // Clock cycles within a segment.
  strobe_divider #(.DIV(SEGMENT_DIV)) u_seg_div (
    .clk(clock_12mhz), .rst(reset), .clear(~stream_d), .advance(stream_q),
    .count(seg_cnt_unused), .last(seg_last), .last_next_c(seg_last_next)
  );

  // Segments within a bit.
  strobe_divider #(.DIV(SEGMENTS_PER_BIT)) u_bseg_div (
    .clk(clock_12mhz), .rst(reset), .clear(~stream_d), .advance(seg_last),
    .count(bseg_cnt_unused), .last(bseg_last), .last_next_c(bseg_last_next)
  );

  // Bits within an LED; count is the MSB-first bit index.
  strobe_divider #(.DIV(BITS_PER_LED)) u_bit_div (
    .clk(clock_12mhz), .rst(reset), .clear(~stream_d), .advance(seg_last & bseg_last),
    .count(bit_cnt), .last(bit_last), .last_next_c(bit_last_next)
  );

  // LEDs within a frame.
  strobe_divider #(.DIV(LEDS_PER_FRAME)) u_led_div (
    .clk(clock_12mhz), .rst(reset), .clear(~stream_d),
    .advance(seg_last & bseg_last & bit_last),
    .count(led_cnt), .last(led_last), .last_next_c(led_last_next_unused)
  );

  // Latch duration counter.
  strobe_divider #(.DIV(LATCH_DIV)) u_latch_div (
    .clk(clock_12mhz), .rst(reset), .clear(~latch_d), .advance(latch_q),
    .count(latch_cnt_unused), .last(latch_last), .last_next_c(latch_last_next_unused)
  );

  // Frame sequencer next state; enable matters only on the tick cycle.
  always_comb begin
    state_d       = state_q;
    frame_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick && enable) begin
          state_d       = STREAM;
          frame_start_d = 1'b1;
        end
      end
      STREAM: begin
        if (frame_done_c) state_d = LATCH;
      end
      LATCH: begin
        if (latch_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered strobes built from next-cycle terminal flags so they land on the terminal cycle.
  always_comb begin
    seg_strobe_d    = seg_last_next;
    bit_strobe_d    = seg_last_next & bseg_last_next;
    led_strobe_d    = seg_last_next & bseg_last_next & bit_last_next;
    encoder_reset_d = latch_d;
    busy_d          = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      frame_start_q   <= 1'b0;
      seg_strobe_q    <= 1'b0;
      bit_strobe_q    <= 1'b0;
      led_strobe_q    <= 1'b0;
      encoder_reset_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      frame_start_q   <= frame_start_d;
      seg_strobe_q    <= seg_strobe_d;
      bit_strobe_q    <= bit_strobe_d;
      led_strobe_q    <= led_strobe_d;
      encoder_reset_q <= encoder_reset_d;
      busy_q          <= busy_d;
    end
  end

`ifdef LED_FRAME_OVERRUN_EN
  logic frame_overrun_q, frame_overrun_d;

  // Sticky flag for ticks dropped because a frame or latch was still running.
  always_comb begin
    frame_overrun_d = frame_overrun_q | (frame_tick & (state_q != IDLE));
  end

  // Overrun flag register, cleared only by reset.
  always_ff @(posedge clock_12mhz or posedge reset) begin
    if (reset) frame_overrun_q <= 1'b0;
    else       frame_overrun_q <= frame_overrun_d;
  end

  assign frame_overrun = frame_overrun_q;
`endif

  assign frame_start        = frame_start_q;
  assign bit_segment_strobe = seg_strobe_q;
  assign bit_strobe         = bit_strobe_q;
  assign led_strobe         = led_strobe_q;
  assign bit_index          = bit_cnt;
  assign led_index          = led_cnt;
  assign encoder_reset      = encoder_reset_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_led_frame_timing_generator.sv
// Bench for led_frame_timing_generator with a reduced configuration
// (SD=3, SPB=2, BPL=4, LEDS=3, RESET_BITS=2, FRAME_DIV=80): frame 72 cycles,
// latch 12 cycles, so every other tick lands while busy and is dropped.
// Honours LED_FRAME_OVERRUN_EN when defined.
module tb_led_frame_timing_generator;

  localparam int SD   = 3;
  localparam int SPB  = 2;
  localparam int BPL  = 4;
  localparam int LPF  = 3;
  localparam int RB   = 2;
  localparam int FD   = 80;
  localparam int BITP = SD * SPB;
  localparam int LEDP = BITP * BPL;
  localparam int FL   = LEDP * LPF;
  localparam int LL   = RB * SD * SPB;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic frame_start, bit_segment_strobe, bit_strobe, led_strobe;
  logic [1:0] bit_index;
  logic [1:0] led_index;
  logic encoder_reset, busy;
  logic act_ovr;

`ifdef LED_FRAME_OVERRUN_EN
  logic frame_overrun;
  assign act_ovr = frame_overrun;
`else
  assign act_ovr = 1'b0;
`endif

  led_frame_timing_generator #(
    .SEGMENT_DIV(SD), .SEGMENTS_PER_BIT(SPB), .BITS_PER_LED(BPL),
    .LEDS_PER_FRAME(LPF), .RESET_BITS(RB), .FRAME_DIV(FD)
  ) dut (
    .clock_12mhz(clk), .reset(rst), .enable(enable),
    .frame_start(frame_start), .bit_segment_strobe(bit_segment_strobe),
    .bit_strobe(bit_strobe), .led_strobe(led_strobe),
    .bit_index(bit_index), .led_index(led_index),
    .encoder_reset(encoder_reset), .busy(busy)
`ifdef LED_FRAME_OVERRUN_EN
    , .frame_overrun(frame_overrun)
`endif
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;
  int cur  = 0;

  // Model state: cycle since reset release, start cycle of current frame.
  int n = 0;
  int fs = -1;
  bit m_ovr = 1'b0;
  bit en_prev = 1'b0;
  int cnt_seg = 0, cnt_bit = 0, cnt_led = 0, cnt_enc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      n = 0; fs = -1; m_ovr = 1'b0; en_prev = 1'b0;
      cnt_seg = 0; cnt_bit = 0; cnt_led = 0; cnt_enc = 0;
    end else begin
      int t;
      bit in_s, in_l;
      bit e_fs, e_bss, e_bs, e_ls, e_er, e_busy;
      int e_bi, e_li;
      logic [10:0] act, exp;
      if (n > 0 && ((n - 1) % FD) == FD - 1) begin
        if (fs >= 0 && (n - 1 - fs) < FL + LL) m_ovr = 1'b1;
        else if (en_prev) fs = n;
      end
      t      = n - fs;
      in_s   = (fs >= 0) && (t < FL);
      in_l   = (fs >= 0) && (t >= FL) && (t < FL + LL);
      e_fs   = in_s && (t == 0);
      e_bss  = in_s && (t % SD == SD - 1);
      e_bs   = in_s && (t % BITP == BITP - 1);
      e_ls   = in_s && (t % LEDP == LEDP - 1);
      e_bi   = in_s ? (t / BITP) % BPL : 0;
      e_li   = in_s ? t / LEDP : 0;
      e_er   = in_l;
      e_busy = in_s || in_l;
      act = {frame_start, bit_segment_strobe, bit_strobe, led_strobe,
             bit_index, led_index, encoder_reset, busy, act_ovr};
`ifdef LED_FRAME_OVERRUN_EN
      exp = {e_fs, e_bss, e_bs, e_ls, 2'(e_bi), 2'(e_li), e_er, e_busy, m_ovr};
`else
      exp = {e_fs, e_bss, e_bs, e_ls, 2'(e_bi), 2'(e_li), e_er, e_busy, 1'b0};
`endif
      vecs++;
      if (act !== exp) begin
        miss++;
        $display("FAIL cycle %0d outputs {fs,seg,bit,led,bi,li,er,busy,ovr}: got %b expected %b",
                 n, act, exp);
      end
      if (n >= 80 && n <= 163) begin
        cnt_seg += int'(bit_segment_strobe);
        cnt_bit += int'(bit_strobe);
        cnt_led += int'(led_strobe);
        cnt_enc += int'(encoder_reset);
      end
      en_prev = enable;
      n++;
    end
  end

  task automatic step_to(input int c);
    repeat (c - cur) @(posedge clk);
    #1;
    cur = c;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset frame_start", 32'(frame_start), 0);
    chk("reset encoder_reset", 32'(encoder_reset), 0);
    chk("reset indices", 32'({bit_index, led_index}), 0);
    rst = 1'b0;
    cur = 0;

    step_to(79);  chk("c79 frame_start", 32'(frame_start), 0);
                  chk("c79 busy", 32'(busy), 0);
    step_to(80);  chk("c80 frame_start", 32'(frame_start), 1);
                  chk("c80 busy", 32'(busy), 1);
    step_to(81);  chk("c81 seg strobe", 32'(bit_segment_strobe), 0);
    step_to(82);  chk("c82 seg strobe", 32'(bit_segment_strobe), 1);
    step_to(85);  chk("c85 bit_strobe", 32'(bit_strobe), 1);
    step_to(86);  chk("c86 bit_index", 32'(bit_index), 1);
    step_to(103); chk("c103 led_strobe", 32'(led_strobe), 1);
    step_to(104); chk("c104 led_index", 32'(led_index), 1);
    step_to(151); chk("c151 final led_strobe", 32'(led_strobe), 1);
                  chk("c151 encoder_reset", 32'(encoder_reset), 0);
    step_to(152); chk("c152 encoder_reset", 32'(encoder_reset), 1);
`ifdef LED_FRAME_OVERRUN_EN
    step_to(159); chk("c159 overrun", 32'(act_ovr), 0);
    step_to(160); chk("c160 overrun", 32'(act_ovr), 1);
`endif
    step_to(161); chk("c161 dropped tick frame_start", 32'(frame_start), 0);
    step_to(163); chk("c163 encoder_reset", 32'(encoder_reset), 1);
    step_to(164); chk("c164 encoder_reset", 32'(encoder_reset), 0);
                  chk("c164 busy", 32'(busy), 0);
    step_to(170);
    chk("frame1 seg strobes", 32'(cnt_seg), 24);
    chk("frame1 bit strobes", 32'(cnt_bit), 12);
    chk("frame1 led strobes", 32'(cnt_led), 3);
    chk("frame1 latch cycles", 32'(cnt_enc), 12);
    step_to(240); chk("c240 frame_start", 32'(frame_start), 1);
    step_to(430); enable = 1'b0;
    step_to(483); chk("c483 encoder_reset", 32'(encoder_reset), 1);
    step_to(560); chk("c560 disabled frame_start", 32'(frame_start), 0);
                  chk("c560 busy", 32'(busy), 0);
    step_to(600); enable = 1'b1;
    step_to(640); chk("c640 resumed frame_start", 32'(frame_start), 1);
    step_to(670);
    #2 rst = 1'b1;
    #1;
    chk("midreset busy", 32'(busy), 0);
    chk("midreset strobes", 32'({frame_start, bit_segment_strobe, bit_strobe, led_strobe}), 0);
    chk("midreset indices", 32'({bit_index, led_index}), 0);
    chk("midreset encoder_reset", 32'(encoder_reset), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cur = 0;
    step_to(20);  chk("post-reset encoder_reset", 32'(encoder_reset), 0);
    step_to(80);  chk("post-reset c80 frame_start", 32'(frame_start), 1);
    step_to(250);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
